dmem_lsu_ctrl: RTL and testbench

- Load/store sequencer between the core's memory stage and the byte-addressed data memory.
- The data memory always writes 4 bytes and returns read data one cycle after an address is presented with write disabled.
- This block aligns every access to a word boundary.
- It performs read-modify-write for byte and halfword stores, and extracts and sign- or zero-extends loads.
- It flags misaligned, out-of-range and illegal accesses without touching memory.

---
 rtl/lsu_defs.sv | 21 ++
 rtl/lsu_lane_align.sv | 47 ++++
 rtl/dmem_lsu_ctrl.sv | 142 ++++++++++++++
 tb/tb_dmem_lsu_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_defs.sv
// Shared definitions for the data-memory load/store sequencer:
// RV32 size codes, FSM state encoding and the default memory size.
package lsu_defs;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MEM_BYTES_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane logic: extracts and extends load data from a memory word and
// merges byte/halfword store data into a memory word (little-endian).
module lsu_lane_align
  import lsu_defs::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] sdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] sdata_rep;
  logic [3:0]  lane_en;

  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_o = {24'd0, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_o = {16'd0, half_sel};
      default: load_o = word_i;
    endcase
  end

  // Replicate store data so every candidate lane already holds the right bytes.
  always_comb begin
    case (funct3_i[1:0])
      2'b00:   sdata_rep = {4{sdata_i[7:0]}};
      2'b01:   sdata_rep = {2{sdata_i[15:0]}};
      default: sdata_rep = sdata_i;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_en[gi] = (funct3_i[1:0] == 2'b00) ? (offset_i == LANE) :
                         (funct3_i[1:0] == 2'b01) ? (offset_i[1] == LANE[1]) : 1'b1;
    assign store_o[8*gi +: 8] = lane_en[gi] ? sdata_rep[8*gi +: 8] : word_i[8*gi +: 8];
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the memory stage and a word-wide data memory:
// aligns accesses, does read-modify-write for sub-word stores, rejects bad accesses.
module dmem_lsu_ctrl
  import lsu_defs::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rw,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              legal;
  logic              acc_err;
  logic [31:0]       load_val;
  logic [31:0]       store_word;

  lsu_lane_align u_lane (
    .word_i   (mem_rdata),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .sdata_i  (wdata_q),
    .load_o   (load_val),
    .store_o  (store_word)
  );

  // Unsigned size codes exist only for loads; alignment follows access size.
  always_comb begin
    case (req_funct3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = !req_addr[0];
      F3_W:    legal = (req_addr[1:0] == 2'b00);
      F3_BU:   legal = !req_we;
      F3_HU:   legal = !req_we && !req_addr[0];
      default: legal = 1'b0;
    endcase
    acc_err = !legal || (req_addr > ADDR_W'(MEM_BYTES - 1));
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          f3_d        = req_funct3;
          off_d       = req_addr[1:0];
          wdata_d     = req_wdata;
          waddr_d     = {req_addr[ADDR_W-1:2], 2'b00};
          rsp_rdata_d = 32'd0;
          rsp_err_d   = acc_err;
          if (acc_err) begin
            state_d = RESP;
          end else if (req_we && (req_funct3 == F3_W)) begin
            mem_wdata_d = req_wdata;
            state_d     = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:   state_d = CAP;
      CAP: begin
        if (we_q) begin
          mem_wdata_d = store_word;
          state_d     = WR;
        end else begin
          rsp_rdata_d = load_val;
          state_d     = RESP;
        end
      end
      WR:   state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      wdata_q     <= 32'd0;
      waddr_q     <= '0;
      mem_wdata_q <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rw    = (state_q == WR) && !rst;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl with a behavioural data memory and an
// expected-response queue filled at accept and drained at response.
module tb_dmem_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          writes;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;
  int   rw_double = 0;
  logic prev_rw = 1'b0;
  logic [31:0] mem_arr [0:255];

  always #5 clk = ~clk;

  dmem_lsu_ctrl #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rw     (mem_rw),
    .mem_rdata  (mem_rdata)
  );

  // Word-wide memory: writes when mem_rw, read data one cycle after the address.
  always @(posedge clk) begin
    if (mem_rw) mem_arr[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem_arr[mem_addr[9:2]];
    if (mem_rw) wr_count <= wr_count + 1;
    if (mem_rw && prev_rw) rw_double <= rw_double + 1;
    prev_rw <= mem_rw;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input int hold);
    exp_t e;
    int   wr0;
    int   lat;
    int   wait_cyc;
    wr0 = wr_count;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    rsp_ready  = 1'b0;
    wait_cyc   = 0;
    while (!req_ready && wait_cyc < 20) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    e.rdata  = exp_rdata;
    e.err    = exp_err;
    e.lat    = exp_lat;
    e.writes = (we && !exp_err) ? 1 : 0;
    exp_q.push_back(e);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e = exp_q.pop_front();
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rsp_latency", 32'(lat), 32'(e.lat));
    check("rsp_rdata", rsp_rdata, e.rdata);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, e.rdata);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("idle_after_rsp", {31'd0, req_ready}, 32'd1);
    check("mem_writes", 32'(wr_count - wr0), 32'(e.writes));
    $display("txn we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             we, f3, addr, wdata, rsp_rdata, rsp_err, lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"},   {31'd0, rsp_err}, 32'd0);
    check({tag, "_mem_rw"},    {31'd0, mem_rw}, 32'd0);
    check({tag, "_mem_addr"},  mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    int wr_before;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    rsp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    do_req(1'b1, 3'b010, 32'h10, 32'hA1B2C3D4, 32'h0,        1'b0, 2, 0); // SW
    do_req(1'b0, 3'b010, 32'h10, 32'h0,        32'hA1B2C3D4, 1'b0, 3, 0); // LW
    do_req(1'b1, 3'b000, 32'h12, 32'h000000EE, 32'h0,        1'b0, 4, 0); // SB
    do_req(1'b0, 3'b010, 32'h10, 32'h0,        32'hA1EEC3D4, 1'b0, 3, 0); // LW
    do_req(1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFA1, 1'b0, 3, 0); // LB
    do_req(1'b0, 3'b100, 32'h13, 32'h0,        32'h000000A1, 1'b0, 3, 0); // LBU
    do_req(1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFA1EE, 1'b0, 3, 0); // LH
    do_req(1'b0, 3'b101, 32'h10, 32'h0,        32'h0000C3D4, 1'b0, 3, 0); // LHU
    do_req(1'b1, 3'b001, 32'h10, 32'h00007788, 32'h0,        1'b0, 4, 0); // SH low half
    do_req(1'b0, 3'b010, 32'h10, 32'h0,        32'hA1EE7788, 1'b0, 3, 0); // LW
    do_req(1'b0, 3'b010, 32'h11, 32'h0,        32'h0,        1'b1, 1, 0); // LW misaligned
    do_req(1'b1, 3'b001, 32'h03, 32'h1234,     32'h0,        1'b1, 1, 0); // SH misaligned
    do_req(1'b0, 3'b010, 32'h400, 32'h0,       32'h0,        1'b1, 1, 0); // out of range
    do_req(1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0); // bad funct3
    do_req(1'b0, 3'b010, 32'h10, 32'h0,        32'hA1EE7788, 1'b0, 3, 5); // stalled consumer
    do_req(1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFF88, 1'b0, 3, 0); // back-to-back

    // Reset during the CAP cycle of a byte store must suppress the write.
    do_req(1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0, 2, 0);
    wr_before  = wr_count;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h20;
    req_wdata  = 32'h000000EE;
    req_valid  = 1'b1;
    check("sb_rst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mem_rw_forced", {31'd0, mem_rw}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midop_reset");
    repeat (3) @(posedge clk);
    #1;
    check("midop_no_write", 32'(wr_count - wr_before), 32'd0);
    check("midop_no_rsp", {31'd0, rsp_valid}, 32'd0);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 32'h11223344, 1'b0, 3, 0);

    check("rw_never_double", 32'(rw_double), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
